vfd_scan_capture: RTL and testbench
===================================

Name: vfd_scan_capture

Overview:
- Captures the time-multiplexed VFD drive produced by the uCOM-43 core and turns it into a stable per-grid segment frame for the video renderer.
- Inputs are the grid strobes and segment lines, assembled at top level from CPU output ports C..I.
- Segments are OR-accumulated over a fixed frame window, then committed to a display buffer with per-grid persistence, so short scan gaps do not flicker.
- The renderer reads the committed buffer through a 1-cycle-latency read port.

Parameters:
- GRIDS, 10, number of VFD grids (1..16).
- SEGS, 16, segment lines per grid.
- FRAME_CLKS, 20'd200000, clk cycles per accumulation frame (>=2).
- DECAY, 3, empty frames a grid keeps its last image before blanking (0..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  sample qualifier; grid/seg are sampled only when high (tied to CPU clk_en).
- grid  in  GRIDS  active-high grid strobes; more than one may be active.
- seg  in  SEGS  active-high segment lines.
- rd_addr  in  4  grid index to read.
- rd_data  out  SEGS  committed segments of grid rd_addr.
- frame_done  out  1  one-cycle pulse on each commit.
- frame_cnt  out  8  committed-frame counter, wraps 255->0.

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset, also when asserted mid-frame: the accumulation buffer, display buffer, all decay counters, the frame timer, frame_cnt, rd_data and frame_done are all cleared to 0.
- Frame timer:
  - Counts 0..FRAME_CLKS-1 and runs every clk, independent of ce.
  - The commit cycle is the cycle with timer == FRAME_CLKS-1. The timer wraps to 0 after it.
- Accumulate (non-commit cycles): for each g, if ce && grid[g], then acc[g] <= acc[g] | seg.
- Commit cycle: for each g, evaluated in parallel:
  - If acc[g] != 0: disp[g] <= acc[g]; dcnt[g] <= DECAY.
  - Else if dcnt[g] != 0: dcnt[g] <= dcnt[g]-1; disp[g] is unchanged.
  - Else: disp[g] <= 0.
  - Result: a grid blanks at the commit of its (DECAY+1)th consecutive empty frame.
- Simultaneous sample and commit:
  - Commit uses acc as it stood before this cycle.
  - On the same cycle, acc[g] <= (ce && grid[g]) ? seg : 0. The sample starts the next frame and is never lost or double-counted.
- frame_done is high for exactly the cycle after the commit. frame_cnt increments on that same cycle.
- Read port:
  - rd_data <= disp[rd_addr], registered, 1-cycle latency.
  - rd_addr >= GRIDS returns 0.
  - A read issued on the commit cycle returns the old value. A read on the next cycle returns the new one.
- seg with no grid active is ignored.
- There is no backpressure. The renderer may read at any time.

Decomposition:
- Shared include file vfd_defs.vh holds:
  - default GRIDS/SEGS for the Scramble board;
  - grid/segment bit maps for ports C..I;
  - the FRAME_CLKS value derived from the system clock.
- One sub-module, vfd_grid_cell: per-grid acc, disp and dcnt registers plus the commit/decay logic. It is instantiated GRIDS times by a generate loop. The frame timer, frame_cnt and read mux stay in the top.

Test Plan (FRAME_CLKS=16, DECAY=2, GRIDS=10, SEGS=16, ce=1 unless stated):
- Set grid=10'b1 and seg=16'h00A5 for 1 cycle in frame 0 -> after the frame_done pulse, rd_addr=0 gives rd_data=16'h00A5, and rd_addr=1 gives 0.
- Drive grid[3] with seg=16'h0001 at timer 2 and seg=16'h0100 at timer 9, ce=0 at timer 9 -> committed grid 3 = 16'h0001.
- Drive grid[5] with seg=16'hFFFF in frame 0 only -> disp[5]=FFFF after commits 1, 2 and 3; 0 after commit 4. frame_cnt=4.
- Drive grid[2] with seg=16'h0003 on the commit cycle only -> frame N commits grid 2 = 0; frame N+1 commits 16'h0003.
- Assert reset at timer 7 with buffers populated -> next cycle: rd_data=0, frame_cnt=0, no frame_done until 16 cycles after reset deasserts.
- Assert grid=10'h3FF with seg=16'h1234 -> all 10 grids commit 16'h1234. rd_addr=12 returns 0.

Source files
------------

// File: rtl/vfd_scan_capture_pkg.sv
// rtl/vfd_scan_capture_pkg.sv - shared definitions for the VFD scan capture block
//
// Purpose:
//   Board defaults for the Scramble cabinet, the uCOM-43 output-port bit maps
//   that feed the grid/segment lines, the frame length derived from the
//   system clock, and the per-grid commit action type.
//   The package has no ports.

package vfd_scan_capture_pkg;

    // Scramble board display geometry.
    localparam int SCRAMBLE_GRIDS = 10;
    localparam int SCRAMBLE_SEGS  = 16;

    // One accumulation frame is one 60 Hz video frame of system clock.
    localparam int          SYS_CLK_HZ          = 12_000_000;
    localparam int          FRAME_RATE_HZ       = 60;
    localparam logic [19:0] SCRAMBLE_FRAME_CLKS = 20'(SYS_CLK_HZ / FRAME_RATE_HZ);

    // Empty frames a grid survives before it blanks.
    localparam int SCRAMBLE_DECAY = 3;

    // Decay counters hold 0..15.
    localparam int DCNT_W = 4;

    // The uCOM-43 output ports that drive the VFD, each 4 bits wide.
    typedef enum logic [2:0] {
        PORT_C = 3'd0,
        PORT_D = 3'd1,
        PORT_E = 3'd2,
        PORT_F = 3'd3,
        PORT_G = 3'd4,
        PORT_H = 3'd5,
        PORT_I = 3'd6
    } ucom_port_e;

    // A single wire on the CPU side: which port and which bit of it.
    typedef struct packed {
        ucom_port_e port;
        logic [1:0] bit_idx;
    } port_bit_t;

    // On the Scramble board the grids occupy C0..E1 and the segments follow
    // on E2..I1, packed contiguously from port C bit 0 upwards.
    localparam int SCRAMBLE_SEG_BASE = SCRAMBLE_GRIDS;

    function automatic port_bit_t flat_to_port_bit(input int flat);
        port_bit_t pb;
        pb.port    = ucom_port_e'(3'(flat / 4));
        pb.bit_idx = 2'(flat % 4);
        return pb;
    endfunction

    // Source wire of grid strobe g.
    function automatic port_bit_t grid_src(input int g);
        return flat_to_port_bit(g);
    endfunction

    // Source wire of segment line s.
    function automatic port_bit_t seg_src(input int s);
        return flat_to_port_bit(SCRAMBLE_SEG_BASE + s);
    endfunction

    // What a grid cell does to its display entry on a commit cycle.
    typedef enum logic [1:0] {
        CELL_LOAD  = 2'd0,  // frame had activity: show it, rearm decay
        CELL_HOLD  = 2'd1,  // empty frame inside the decay window: keep image
        CELL_BLANK = 2'd2   // decay exhausted: clear the grid
    } cell_action_e;

endpackage

// File: rtl/vfd_grid_cell.sv
// rtl/vfd_grid_cell.sv - per-grid segment accumulator, display entry and decay
//
// Purpose:
//   Holds one grid's accumulation register, committed display value and
//   decay counter. Segments are OR-ed in while the grid is strobed; on a
//   commit the accumulated image is published or, if the frame was empty,
//   the previous image is kept for DECAY frames before blanking.
//
// Ports:
//   clk     in  1     system clock
//   reset   in  1     synchronous, active-high reset
//   commit  in  1     frame commit cycle from the shared frame timer
//   sample  in  1     this grid is strobed and the CPU sample qualifier is high
//   seg     in  SEGS  segment lines
//   disp    out SEGS  committed segments for this grid

module vfd_grid_cell
    import vfd_scan_capture_pkg::*;
#(
    parameter int SEGS  = SCRAMBLE_SEGS,
    parameter int DECAY = SCRAMBLE_DECAY
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            commit,
    input  logic            sample,
    input  logic [SEGS-1:0] seg,
    output logic [SEGS-1:0] disp
);

    logic [SEGS-1:0]   acc;
    logic [DCNT_W-1:0] dcnt;
    cell_action_e      action;

    // The decision only matters on commit cycles but is cheap to keep live.
    always_comb begin
        action = CELL_BLANK;
        if (acc != '0) begin
            action = CELL_LOAD;
        end else if (dcnt != '0) begin
            action = CELL_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            disp <= '0;
            dcnt <= '0;
        end else if (commit) begin
            // The commit publishes the old frame; a sample landing on this
            // same cycle seeds the next frame instead of being merged.
            acc <= sample ? seg : '0;
            unique case (action)
                CELL_LOAD: begin
                    disp <= acc;
                    dcnt <= DCNT_W'(DECAY);
                end
                CELL_HOLD: begin
                    dcnt <= dcnt - 1'b1;
                end
                default: begin
                    disp <= '0;
                end
            endcase
        end else if (sample) begin
            acc <= acc | seg;
        end
    end

endmodule

// File: rtl/vfd_scan_capture.sv
// rtl/vfd_scan_capture.sv - turns multiplexed VFD drive into a stable per-grid frame
//
// Purpose:
//   Samples the uCOM-43 grid strobes and segment lines, OR-accumulates the
//   segments per grid over a fixed frame window, commits each frame into a
//   persistent display buffer and serves it to the renderer through a
//   registered read port.
//
// Ports:
//   clk         in  1      system clock
//   reset       in  1      synchronous, active-high reset
//   ce          in  1      sample qualifier (CPU clock enable)
//   grid        in  GRIDS  active-high grid strobes, several may be active
//   seg         in  SEGS   active-high segment lines
//   rd_addr     in  4      grid index to read
//   rd_data     out SEGS   committed segments of grid rd_addr, 1-cycle latency
//   frame_done  out 1      one-cycle pulse on the cycle after each commit
//   frame_cnt   out 8      committed-frame counter, wraps 255 -> 0

module vfd_scan_capture
    import vfd_scan_capture_pkg::*;
#(
    parameter int          GRIDS      = SCRAMBLE_GRIDS,
    parameter int          SEGS       = SCRAMBLE_SEGS,
    parameter logic [19:0] FRAME_CLKS = SCRAMBLE_FRAME_CLKS,
    parameter int          DECAY      = SCRAMBLE_DECAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [GRIDS-1:0] grid,
    input  logic [SEGS-1:0]  seg,
    input  logic [3:0]       rd_addr,
    output logic [SEGS-1:0]  rd_data,
    output logic             frame_done,
    output logic [7:0]       frame_cnt
);

    localparam int TW = $clog2(FRAME_CLKS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_CLKS - 20'd1);

    logic [TW-1:0] timer;
    logic          commit;

    // The timer free-runs on clk so frame length is fixed in wall time
    // regardless of how often the CPU is enabled.
    assign commit = (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (commit) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            frame_done <= commit;
            if (commit) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // The display view is padded to the full 4-bit address space so that
    // addresses past the last grid read back as blank.
    logic [SEGS-1:0] disp_pad [16];

    for (genvar g = 0; g < 16; g++) begin : g_grid
        if (g < GRIDS) begin : g_cell
            vfd_grid_cell #(
                .SEGS  (SEGS),
                .DECAY (DECAY)
            ) u_cell (
                .clk    (clk),
                .reset  (reset),
                .commit (commit),
                .sample (ce & grid[g]),
                .seg    (seg),
                .disp   (disp_pad[g])
            );
        end else begin : g_blank
            assign disp_pad[g] = '0;
        end
    end

    // Reading the pre-commit buffer means a read on the commit cycle sees
    // the old frame and the following cycle sees the new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= disp_pad[rd_addr];
        end
    end

endmodule

// File: tb/tb_vfd_scan_capture.sv
// tb/tb_vfd_scan_capture.sv - directed self-checking bench for vfd_scan_capture

module tb_vfd_scan_capture;

    localparam int GRIDS  = 10;
    localparam int SEGS   = 16;
    localparam int FRAMES = 16;
    localparam int DECAY  = 2;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             ce      = 1'b1;
    logic [GRIDS-1:0] grid    = '0;
    logic [SEGS-1:0]  seg     = '0;
    logic [3:0]       rd_addr = '0;
    logic [SEGS-1:0]  rd_data;
    logic             frame_done;
    logic [7:0]       frame_cnt;

    int checks = 0;
    int errors = 0;
    int tcur   = 0;  // timer value of the cycle whose inputs are being driven

    vfd_scan_capture #(
        .GRIDS      (GRIDS),
        .SEGS       (SEGS),
        .FRAME_CLKS (20'd16),
        .DECAY      (DECAY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .grid       (grid),
        .seg        (seg),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tcur = (tcur + 1) % FRAMES;
    endtask

    task automatic run_to(input int t);
        while (tcur != t) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce    = 1'b1;
        grid  = '0;
        seg   = '0;
        tick();
        tick();
        reset = 1'b0;
        tcur  = 0;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [SEGS-1:0] exp, input string tag);
        rd_addr = addr;
        tick();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int seen;

        // Reset state
        do_reset();
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'h0);

        // Single strobe on grid 0; stray segments with no grid are ignored
        grid = 10'b1;
        seg  = 16'h00A5;
        tick();
        grid = '0;
        seg  = '0;
        run_to(5);
        seg = 16'hFFFF;
        tick();
        seg = '0;
        run_to(15);
        rd_addr = 4'd0;
        tick();
        chk("read_on_commit_old", 32'(rd_data), 32'h0);
        chk("frame_done_pulse", 32'(frame_done), 32'h1);
        chk("frame_cnt_1", 32'(frame_cnt), 32'h1);
        tick();
        chk("read_after_commit_new", 32'(rd_data), 32'h00A5);
        chk("frame_done_one_cycle", 32'(frame_done), 32'h0);
        rd(4'd1, 16'h0000, "grid1_empty");

        // ce low masks a strobe
        do_reset();
        run_to(2);
        grid = 10'b1 << 3;
        seg  = 16'h0001;
        tick();
        grid = '0;
        seg  = '0;
        run_to(9);
        ce   = 1'b0;
        grid = 10'b1 << 3;
        seg  = 16'h0100;
        tick();
        ce   = 1'b1;
        grid = '0;
        seg  = '0;
        run_to(15);
        tick();
        rd(4'd3, 16'h0001, "ce_masked_sample");

        // Decay: image survives DECAY empty frames, blanks on the next
        do_reset();
        grid = 10'b1 << 5;
        seg  = 16'hFFFF;
        tick();
        grid = '0;
        seg  = '0;
        for (int k = 1; k <= 4; k++) begin
            run_to(15);
            tick();
            rd(4'd5, (k <= 3) ? 16'hFFFF : 16'h0000, $sformatf("decay_commit_%0d", k));
        end
        chk("decay_frame_cnt", 32'(frame_cnt), 32'd4);

        // Sample on the commit cycle belongs to the next frame
        do_reset();
        run_to(15);
        grid = 10'b1 << 2;
        seg  = 16'h0003;
        tick();
        grid = '0;
        seg  = '0;
        rd(4'd2, 16'h0000, "commit_sample_frame_n");
        run_to(15);
        tick();
        rd(4'd2, 16'h0003, "commit_sample_frame_n1");

        // Mid-frame reset clears everything and restarts the timer
        chk("pre_reset_frame_cnt", 32'(frame_cnt), 32'd2);
        run_to(7);
        reset   = 1'b1;
        rd_addr = 4'd2;
        tick();
        chk("midreset_rd_data", 32'(rd_data), 32'h0);
        chk("midreset_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("midreset_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        tcur  = 0;
        seen  = 0;
        repeat (15) begin
            tick();
            if (frame_done) seen++;
        end
        chk("no_early_frame_done", 32'(seen), 32'd0);
        tick();
        chk("frame_done_after_16", 32'(frame_done), 32'h1);
        rd(4'd2, 16'h0000, "midreset_disp_cleared");

        // All grids at once, and out-of-range addresses
        do_reset();
        grid = 10'h3FF;
        seg  = 16'h1234;
        tick();
        grid = '0;
        seg  = '0;
        run_to(15);
        tick();
        for (int g = 0; g < GRIDS; g++) begin
            rd(4'(g), 16'h1234, $sformatf("all_grids_%0d", g));
        end
        rd(4'd12, 16'h0000, "addr_12_blank");
        rd(4'd15, 16'h0000, "addr_15_blank");

        // frame_cnt wraps 255 -> 0
        do_reset();
        for (int i = 0; i < 255; i++) begin
            run_to(15);
            tick();
        end
        chk("frame_cnt_255", 32'(frame_cnt), 32'd255);
        run_to(15);
        tick();
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        chk("frame_done_at_wrap", 32'(frame_done), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
